qrd_matrix_feeder: RTL and testbench
====================================

Name: qrd_matrix_feeder

Overview:
- Parametrised front end for the systolic complex QR-decomposition core.
- Accepts an N x N complex matrix H as a row-major element stream with a valid/ready handshake, and stores it in a two-bank (ping-pong) buffer.
- Drives the core's N skewed row lanes with the augmented rows [H | I], or H alone, plus first-element flags, honouring the core's ready/stall signal.
- Generalises the fixed 4x4 hand-fed stimulus to any N, with back-to-back frames, a selectable augment mode and framing checks.

Parameters:
- N, 4, matrix dimension and lane count (2..8)
- W, 14, signed element width (real and imag each)
- FRAC, 10, fraction bits; identity "1" = 1<<FRAC

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input element valid
- s_ready  out  1  feeder can accept an element
- s_data_r  in  W  element real part
- s_data_i  in  W  element imag part
- s_last  in  1  marks the final element (index N*N-1) of a matrix
- aug_en  in  1  1: feed [H|I] (2N columns); 0: feed H only (N columns)
- core_ready  in  1  core accepts the current feed step (in_ready)
- feed_valid  out  1  lanes carry a valid feed step
- lane_r  out  N*W  lane k real part at bits [k*W +: W]
- lane_i  out  N*W  lane k imag part
- lane_f  out  N-1  first flag per lane k < N-1
- frame_err  out  1  one-cycle pulse on a framing error
- frames_fed  out  16  count of completed matrices, wraps

Behaviour:
- Everything is driven by clk. Reset is synchronous and active-high on rst.
- Reset values:
  - s_ready = 1
  - feed_valid = 0
  - lane_r, lane_i, lane_f = 0
  - frame_err = 0
  - frames_fed = 0
  - both banks empty, write and read bank = 0, element index = 0
- Reset mid-operation: partially loaded and partially fed frames are discarded; the next cycle starts from the reset state.
- Load side:
  - An element is accepted on an edge where s_valid && s_ready.
  - Elements go into the write bank at index e (row e/N, column e%N); e then increments.
  - aug_en is latched per bank when element 0 is accepted.
  - On acceptance of e = N*N-1 with s_last = 1: the bank is marked full, write bank toggles, e = 0.
  - s_ready = 0 while the write bank is full, i.e. both banks are full.
- Framing error: s_last = 1 at e < N*N-1, or s_last = 0 at e = N*N-1.
  - frame_err pulses for one cycle.
  - The partial frame is discarded and e = 0; the bank stays empty.
  - The error element itself is dropped.
- Feed side, states IDLE and FEED:
  - IDLE -> FEED when the read bank is full. Step t = 0 is presented with feed_valid = 1.
  - Lanes are registered. The first step is visible in the cycle after the edge that completes the frame, so latency is 1 cycle.
  - In FEED, t advances only on an edge with core_ready = 1. While core_ready = 0, all lane outputs and lane_f hold.
- Columns per row C = 2N if aug_en (latched) else N. Last step T = C + N - 2.
- Lane k at step t:
  - If k <= t < k + C, let j = t - k:
    - j < N: H[k][j].
    - Otherwise: real = (j - N == k) ? 1<<FRAC : 0; imag = 0.
  - Outside that window: 0 + 0j.
- lane_f[k] = 1 exactly at step t = 2k, for k < N-1.
- When step T is consumed:
  - The read bank is marked empty, read bank toggles, frames_fed increments.
  - If the other bank is already full, go directly to step 0 of the next frame (no bubble). Otherwise go to IDLE with feed_valid = 0 and lanes = 0.
- Simultaneous events:
  - A bank freed and the other bank's frame completing on the same edge are both processed.
  - s_ready may rise on the edge after a bank frees.

Test Plan:
1. Reset: assert rst for 2 cycles mid-feed -> next cycle feed_valid = 0, lanes = 0, s_ready = 1, frames_fed = 0.
2. Single frame: N=4, aug_en=1, core_ready=1, H[i][j] = (16i+j+1) - (16i+j+1)j.
   - feed_valid rises the cycle after s_last is accepted.
   - Step 0: lane0 = 1-1j, other lanes 0. Step 4: lane0 real = 1024. Step 6: lane1 real = 1024. Step 10: lane3 real = 1024.
   - lane_f[0..2] high at steps 0, 2, 4.
   - feed_valid high for exactly 11 cycles; frames_fed = 1.
3. Stall: same frame with core_ready = 0 for 3 cycles at step 5 -> lanes hold the step-5 values; the feed spans 14 cycles with identical data sequence.
4. Back-to-back: stream 3 frames continuously.
   - s_ready drops after frame 2 loads while frame 1 is feeding.
   - Frame 2 step 0 appears on the cycle after frame 1 step 10 (no bubble).
   - frames_fed = 3 at the end.
5. aug_en = 0: feed lasts 7 steps, no 1024 values; lane3 at step 6 = H[3][3] = 52-52j.
6. Framing: s_last at element 10 -> frame_err pulses once, no feed starts; the following correct frame feeds normally with values as in scenario 2.

Source files
------------

// File: rtl/qrd_matrix_feeder.sv
// Ping-pong matrix buffer feeding N skewed row lanes ([H|I] or H) into the systolic QR core.
// Load side accepts a row-major element stream; feed side walks skewed steps under core back-pressure.
module qrd_matrix_feeder #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 14,
    parameter int unsigned FRAC = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data_r,
    input  logic [W-1:0]     s_data_i,
    input  logic             s_last,
    input  logic             aug_en,
    input  logic             core_ready,
    output logic             feed_valid,
    output logic [N*W-1:0]   lane_r,
    output logic [N*W-1:0]   lane_i,
    output logic [N-2:0]     lane_f,
    output logic             frame_err,
    output logic [15:0]      frames_fed
);
    localparam int unsigned NN = N * N;
    localparam int unsigned EW = $clog2(NN);
    localparam int unsigned TW = $clog2(3 * N);
    localparam logic [EW-1:0] E_LAST = EW'(NN - 1);
    localparam logic [W-1:0]  ONE    = W'(1) << FRAC;

    typedef enum logic {IDLE = 1'b0, FEED = 1'b1} state_t;

    logic [W-1:0]  mem_r [2][NN];
    logic [W-1:0]  mem_i [2][NN];
    logic [1:0]    full, aug, full_now;
    logic          wr_bank, rd_bank, rd_n;
    logic [EW-1:0] e;
    logic [TW-1:0] t, t_n;
    state_t        state, state_n;
    logic          accept, at_last, complete, bad;
    logic          free, present, hold;
    logic [N*W-1:0] nxt_r, nxt_i;
    logic [N-2:0]   nxt_f;
    int unsigned    tt, cols, j;

    function automatic logic [TW-1:0] last_step(input logic a);
        return a ? TW'(3 * N - 2) : TW'(2 * N - 2);
    endfunction

    assign s_ready    = !full[wr_bank];
    assign accept     = s_valid && s_ready;
    assign at_last    = (e == E_LAST);
    assign complete   = accept && at_last && s_last;
    assign bad        = accept && (at_last != s_last);
    assign feed_valid = (state == FEED);
    // A frame completing this edge counts as full so its step 0 appears one cycle later.
    assign full_now   = full | (complete ? (2'b01 << wr_bank) : 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            e         <= '0;
            wr_bank   <= 1'b0;
            aug       <= '0;
            full      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad;
            if (accept) begin
                e <= (bad || complete) ? '0 : e + 1'b1;
                if (e == '0 && !bad) aug[wr_bank] <= aug_en;
                if (complete) wr_bank <= ~wr_bank;
            end
            if (complete) full[wr_bank] <= 1'b1;
            if (free)     full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !bad) begin
            mem_r[wr_bank][e] <= s_data_r;
            mem_i[wr_bank][e] <= s_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_n;
            t       <= t_n;
            rd_bank <= rd_n;
        end
    end

    always_comb begin
        state_n = state;
        t_n     = t;
        rd_n    = rd_bank;
        free    = 1'b0;
        present = 1'b0;
        hold    = 1'b0;
        case (state)
            IDLE: begin
                if (full_now[rd_bank]) begin
                    state_n = FEED;
                    t_n     = '0;
                    present = 1'b1;
                end
            end
            FEED: begin
                if (!core_ready) begin
                    hold = 1'b1;
                end else if (t == last_step(aug[rd_bank])) begin
                    free = 1'b1;
                    rd_n = ~rd_bank;
                    t_n  = '0;
                    if (full_now[~rd_bank]) present = 1'b1;
                    else                    state_n = IDLE;
                end else begin
                    t_n     = t + 1'b1;
                    present = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Lane contents for step t_n of bank rd_n; lane k sees column t_n - k of its augmented row.
    always_comb begin
        nxt_r = '0;
        nxt_i = '0;
        nxt_f = '0;
        j     = 0;
        tt    = int'(t_n);
        cols  = aug[rd_n] ? 2 * N : N;
        for (int unsigned k = 0; k < N; k++) begin
            if (tt >= k && tt < k + cols) begin
                j = tt - k;
                if (j < N) begin
                    nxt_r[k*W +: W] = mem_r[rd_n][EW'(k * N + j)];
                    nxt_i[k*W +: W] = mem_i[rd_n][EW'(k * N + j)];
                end else if (j - N == k) begin
                    nxt_r[k*W +: W] = ONE;
                end
            end
        end
        for (int unsigned k = 0; k < N - 1; k++) begin
            nxt_f[k] = (tt == 2 * k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r     <= '0;
            lane_i     <= '0;
            lane_f     <= '0;
            frames_fed <= '0;
        end else begin
            if (!hold) begin
                lane_r <= present ? nxt_r : '0;
                lane_i <= present ? nxt_i : '0;
                lane_f <= present ? nxt_f : '0;
            end
            if (free) frames_fed <= frames_fed + 16'd1;
        end
    end
endmodule

// File: tb/tb_qrd_matrix_feeder.sv
// Scoreboard bench for qrd_matrix_feeder: expected feed steps are queued per issued frame
// from an augmented-matrix model; a negedge monitor compares every presented step.
module tb_qrd_matrix_feeder;
    localparam int N = 4, W = 14, FRAC = 10, NN = N * N;

    typedef struct {
        logic [N*W-1:0] r;
        logic [N*W-1:0] i;
        logic [N-2:0]   f;
        bit             last;
    } step_t;

    logic clk = 1'b0, rst = 1'b1;
    logic s_valid = 1'b0, s_last = 1'b0, aug_en = 1'b0, core_ready = 1'b1;
    logic [W-1:0] s_data_r = '0, s_data_i = '0;
    logic s_ready, feed_valid, frame_err;
    logic [N*W-1:0] lane_r, lane_i;
    logic [N-2:0] lane_f;
    logic [15:0] frames_fed;

    step_t q[$];
    int errors = 0, checks = 0;
    int pops = 0, err_seen = 0, exp_err = 0, stall_base = 0, cr_mode = 0;
    logic [15:0] exp_fed = '0;
    bit gaps = 0, s_low_seen = 0;
    logic [W-1:0] cur_r[NN], cur_i[NN];

    qrd_matrix_feeder #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data_r(s_data_r), .s_data_i(s_data_i), .s_last(s_last), .aug_en(aug_en),
        .core_ready(core_ready), .feed_valid(feed_valid), .lane_r(lane_r), .lane_i(lane_i),
        .lane_f(lane_f), .frame_err(frame_err), .frames_fed(frames_fed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: augmented row k = [H[k][*] | e_k]; lane k at step t carries column t-k.
    task automatic push_frame(input bit a);
        int cols = a ? 2 * N : N;
        for (int t = 0; t <= cols + N - 2; t++) begin
            step_t s;
            s.r = '0; s.i = '0; s.f = '0;
            s.last = (t == cols + N - 2);
            for (int k = 0; k < N; k++) begin
                int c = t - k;
                if (c >= 0 && c < cols) begin
                    if (c < N) begin
                        s.r[k*W +: W] = cur_r[k*N + c];
                        s.i[k*W +: W] = cur_i[k*N + c];
                    end else if (c - N == k) begin
                        s.r[k*W +: W] = W'(1 << FRAC);
                    end
                end
                if (k < N - 1 && t == 2 * k) s.f[k] = 1'b1;
            end
            q.push_back(s);
        end
    endtask

    // Called at a negedge; returns at the negedge after the element is accepted.
    task automatic send_elem(input int idx, input bit last, input bit a);
        int n = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        s_valid  = 1'b1;
        s_data_r = cur_r[idx];
        s_data_i = cur_i[idx];
        s_last   = last;
        aug_en   = (idx == 0) ? a : 1'($urandom);
        while (!s_ready && n < 2000) begin
            s_low_seen = 1;
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // kind 0: good frame; 1: s_last early at element pos; 2: s_last missing at the end.
    task automatic send_frame(input bit a, input int kind, input int pos);
        if (kind == 0) push_frame(a);
        else exp_err++;
        if (kind == 1) begin
            for (int x = 0; x <= pos; x++) send_elem(x, x == pos, a);
        end else begin
            for (int x = 0; x < NN; x++) send_elem(x, (kind == 0) && (x == NN - 1), a);
        end
    endtask

    task automatic fill_directed();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                cur_r[r*N + c] = W'(16 * r + c + 1);
                cur_i[r*N + c] = W'(-(16 * r + c + 1));
            end
    endtask

    task automatic count_feed(output int n);
        n = 0;
        while (feed_valid && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || feed_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 0, 1);
    endtask

    // Core back-pressure generator.
    initial begin
        int cnt3 = 0, stall_n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cr_mode != 3) stall_n = 0;
            case (cr_mode)
                0: core_ready = 1'b1;
                1: core_ready = ($urandom_range(0, 9) < 6);
                2: begin cnt3++; core_ready = (cnt3 % 3 == 0); end
                default: begin
                    core_ready = !(feed_valid && (pops - stall_base == 5) && stall_n < 3);
                    if (!core_ready) stall_n++;
                end
            endcase
        end
    end

    // Monitor: compares every presented step; pops when the core consumes it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                exp_fed = '0;
            end else begin
                if (frame_err) err_seen++;
                chk("frames_fed", frames_fed, exp_fed);
                if (feed_valid) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_feed: r=%h i=%h f=%b with no step pending", lane_r, lane_i, lane_f);
                    end else begin
                        if (lane_r !== q[0].r || lane_i !== q[0].i || lane_f !== q[0].f) begin
                            errors++;
                            $display("FAIL lane_step: got r=%h i=%h f=%b, expected r=%h i=%h f=%b",
                                     lane_r, lane_i, lane_f, q[0].r, q[0].i, q[0].f);
                        end
                        if (core_ready) begin
                            pops++;
                            if (q[0].last) exp_fed++;
                            void'(q.pop_front());
                        end
                    end
                end else begin
                    chk("idle_lanes_zero", (lane_r == '0 && lane_i == '0 && lane_f == '0) ? 1 : 0, 1);
                end
            end
        end
    end

    initial begin
        int n, base, drops;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", s_ready, 1);
        chk("reset_feed_valid", feed_valid, 0);
        chk("reset_frames_fed", frames_fed, 0);
        chk("reset_frame_err", frame_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single augmented frame: latency 1 and 11 steps at full rate.
        fill_directed();
        send_frame(1, 0, 0);
        chk("latency_feed_valid", feed_valid, 1);
        count_feed(n);
        chk("aug_feed_len", n, 11);
        wait_idle();

        // Three-cycle stall at step 5.
        stall_base = pops;
        cr_mode = 3;
        send_frame(1, 0, 0);
        count_feed(n);
        chk("stall_feed_len", n, 14);
        wait_idle();
        cr_mode = 0;

        // Reset mid-feed.
        send_frame(1, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset_feed_valid", feed_valid, 0);
        chk("midreset_lanes", (lane_r == '0 && lane_i == '0 && lane_f == '0) ? 1 : 0, 1);
        chk("midreset_s_ready", s_ready, 1);
        chk("midreset_frames_fed", frames_fed, 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back frames against a slow core: no bubble between frames.
        cr_mode = 2;
        s_low_seen = 0;
        base = 0;
        drops = 0;
        fork
            begin
                for (int fr = 0; fr < 3; fr++) begin
                    for (int x = 0; x < NN; x++) begin
                        cur_r[x] = W'(fr * 100 + x);
                        cur_i[x] = W'(-(fr * 7 + x));
                    end
                    send_frame(1, 0, 0);
                end
            end
            begin
                n = 0;
                while (!feed_valid && n < 2000) begin @(negedge clk); n++; end
                while (frames_fed != 16'(base + 3) && n < 4000) begin
                    if (!feed_valid) drops++;
                    @(negedge clk);
                    n++;
                end
                if (n >= 4000) chk("b2b_timeout", 0, 1);
            end
        join
        wait_idle();
        chk("b2b_s_ready_dropped", s_low_seen, 1);
        chk("b2b_bubbles", drops, 0);
        chk("b2b_frames_fed", frames_fed, 3);
        cr_mode = 0;

        // H-only feed: 7 steps.
        fill_directed();
        send_frame(0, 0, 0);
        count_feed(n);
        chk("plain_feed_len", n, 7);
        wait_idle();

        // Early s_last at element 10, then a correct frame.
        send_frame(1, 1, 10);
        repeat (4) @(negedge clk);
        chk("frame_err_pulses", err_seen, exp_err);
        chk("no_feed_after_err", feed_valid, 0);
        send_frame(1, 0, 0);
        wait_idle();

        // Randomized frames, errors, gaps and back-pressure.
        cr_mode = 1;
        gaps = 1;
        for (int fr = 0; fr < 12; fr++) begin
            int kind = $urandom_range(0, 9);
            for (int x = 0; x < NN; x++) begin
                cur_r[x] = W'($urandom);
                cur_i[x] = W'($urandom);
            end
            if (kind < 7) send_frame(1'($urandom), 0, 0);
            else if (kind < 9) send_frame(1'($urandom), 1, $urandom_range(0, NN - 2));
            else send_frame(1'($urandom), 2, 0);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("total_frame_err", err_seen, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
